// File: rtl/router_output_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : router_output_arbiter
// Description : Output-port arbiter for one mesh-router output channel.
//               NUM_REQ input buffers compete for the port. There is one
//               single-entry buffer per virtual channel (VC0 even, VC1 odd).
//               In each cycle the VC selected by polarity is filled by a
//               round-robin grant. The opposite VC is drained onto the link.
//               Optional build macro ARB_STATS_EN adds per-requester 16-bit
//               saturating grant counters readable through stat_sel/stat_cnt.
// Ports       : clk       - clock, all state updates on posedge
//               reset     - synchronous active-low reset (0 = reset)
//               polarity  - global phase, 0 = even cycle, 1 = odd cycle
//               req_vld   - per-requester packet-valid
//               req_data  - packed requester packets, MSB of each is VC bit
//               req_gnt   - one-hot grant, requester pops this cycle
//               out_ri    - downstream ready for the VC being sent
//               out_so    - link send strobe
//               out_do    - link data
//               stat_sel  - counter select           (ARB_STATS_EN only)
//               stat_cnt  - selected grant counter   (ARB_STATS_EN only)
// Revision    : 1.0 - initial release
// ============================================================================
module router_output_arbiter #(
   parameter int DATA_WIDTH = 64,
   parameter int NUM_REQ    = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          polarity,
   input  logic [NUM_REQ-1:0]            req_vld,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_gnt,
   input  logic                          out_ri,
   output logic                          out_so,
`ifdef ARB_STATS_EN
   input  logic [$clog2(NUM_REQ)-1:0]    stat_sel,
   output logic [15:0]                   stat_cnt,
`endif
   output logic [DATA_WIDTH-1:0]         out_do
);

   localparam int               SEL_W   = $clog2(NUM_REQ);
   localparam logic [SEL_W-1:0] PTR_RST = SEL_W'(NUM_REQ - 1);

   // Per-VC state: index 0 = VC0 (even), index 1 = VC1 (odd)
   logic [1:0]            full;
   logic [DATA_WIDTH-1:0] vc_buf [2];
   logic [SEL_W-1:0]      rr_ptr [2];

   logic [NUM_REQ-1:0]    eligible;
   logic [SEL_W-1:0]      cand_sel;
   logic                  found;
   logic [SEL_W-1:0]      winner;
   logic [DATA_WIDTH-1:0] win_data;
   logic                  grant_en;
   logic                  drain_vc;

   assign drain_vc = ~polarity;

   // Only packets tagged with the VC currently being filled may compete
   always_comb begin
      eligible = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         eligible[i] = req_vld[i] & (req_data[i*DATA_WIDTH + DATA_WIDTH-1] == polarity);
      end
   end

   // Round-robin search starting one past the last winner of this VC
   always_comb begin
      found    = 1'b0;
      winner   = '0;
      cand_sel = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand_sel = SEL_W'((int'(rr_ptr[polarity]) + k) % NUM_REQ);
         if (!found && eligible[cand_sel]) begin
            found  = 1'b1;
            winner = cand_sel;
         end
      end
   end

   always_comb begin
      win_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (winner == SEL_W'(i)) begin
            win_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Reset gates every output so nothing leaves the block while reset is held
   assign grant_en = reset & ~full[polarity] & found;

   always_comb begin
      req_gnt = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_gnt[i] = grant_en & (winner == SEL_W'(i));
      end
   end

   assign out_so = reset & full[drain_vc] & out_ri;
   assign out_do = (reset & full[drain_vc]) ? vc_buf[drain_vc] : '0;

   // Fill and drain always address different VCs, so both may act in one cycle
   always_ff @(posedge clk) begin
      if (!reset) begin
         full      <= '0;
         vc_buf[0] <= '0;
         vc_buf[1] <= '0;
         rr_ptr[0] <= PTR_RST;
         rr_ptr[1] <= PTR_RST;
      end else begin
         if (grant_en) begin
            vc_buf[polarity] <= win_data;
            full[polarity]   <= 1'b1;
            rr_ptr[polarity] <= winner;
         end
         if (out_so) begin
            full[drain_vc] <= 1'b0;
         end
      end
   end

`ifdef ARB_STATS_EN
   // Counter slots are padded to a power of two so any stat_sel value indexes
   // a defined slot; unused slots read as zero.
   localparam int CNT_SLOTS = 2 ** SEL_W;

   logic [CNT_SLOTS*16-1:0] cnt_vec;

   generate
      for (genvar g = 0; g < CNT_SLOTS; g++) begin : g_cnt
         if (g < NUM_REQ) begin : g_live
            logic [15:0] count;
            always_ff @(posedge clk) begin
               if (!reset) begin
                  count <= '0;
               end else if (req_gnt[g] && (count != 16'hFFFF)) begin
                  count <= count + 16'd1;
               end
            end
            assign cnt_vec[g*16 +: 16] = count;
         end else begin : g_pad
            assign cnt_vec[g*16 +: 16] = 16'h0000;
         end
      end
   endgenerate

   assign stat_cnt = cnt_vec[stat_sel*16 +: 16];
`endif

endmodule
`default_nettype wire
